// File: rtl/eu_pkg.sv
// Shared definitions for the EU issue sequencer: opcodes, instruction fields, states.
// No logic; opcode classification helper only.
// Imported by eu_issue_ctrl and eu_mem_timer.
package eu_pkg;

    localparam logic [3:0] OP_ALU_MIN = 4'h0;
    localparam logic [3:0] OP_ALU_MAX = 4'h3;
    localparam logic [3:0] OP_LD      = 4'h4;
    localparam logic [3:0] OP_ST      = 4'h5;
    localparam logic [3:0] OP_NOP     = 4'hF;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int DEST_HI = 11;
    localparam int DEST_LO = 9;
    localparam int SRCA_HI = 8;
    localparam int SRCA_LO = 6;
    localparam int SRCB_HI = 5;
    localparam int SRCB_LO = 3;

    localparam logic [15:0] IR_NOP = 16'hF000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LD_WAIT,
        ST_ST_WAIT,
        ST_WB
    } eu_seq_state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_NOP,
        CLS_ILL
    } op_class_t;

    function automatic op_class_t op_class(input logic [3:0] opc);
        op_class_t cls;
        if (opc <= OP_ALU_MAX)   cls = CLS_ALU;
        else if (opc == OP_LD)   cls = CLS_LD;
        else if (opc == OP_ST)   cls = CLS_ST;
        else if (opc == OP_NOP)  cls = CLS_NOP;
        else                     cls = CLS_ILL;
        return cls;
    endfunction

endpackage

// File: rtl/eu_mem_timer.sv
// Memory-wait watchdog: counts cycles while enabled, flags the last allowed cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clear has priority over enable.
module eu_mem_timer
    import eu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = enable && (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/eu_issue_ctrl.sv
// Single-issue sequencer driving EU operand/opcode inputs and gating RF/DMEM writes.
// Latency accept->retire: ALU 3, LD 4+wait, ST 3+wait cycles.
// Backpressure: instr_ready only in IDLE; memory waits stall until dmem_ack or timeout.
module eu_issue_ctrl
    import eu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [3:0]       eu_opcode,
    output logic [2:0]       eu_opA_adr,
    output logic [2:0]       eu_opB_adr,
    output logic [2:0]       eu_dest,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             rf_wr_gate,
    output logic             dmem_wr_gate,
    output logic             busy,
    output logic             err_illegal,
    output logic             err_timeout,
    input  logic             err_clr,
    output logic [CNT_W-1:0] retire_count
);

    eu_seq_state_t state, state_nxt;
    logic [15:0]   ir;
    op_class_t     in_cls, ir_cls;
    logic          ir_load;
    logic          retire;
    logic          set_illegal;
    logic          set_timeout;
    logic          tmr_clear;
    logic          tmr_en;
    logic          tmr_expired;
    logic          unused_rsvd;

    assign in_cls      = op_class(instr[OPC_HI:OPC_LO]);
    assign ir_cls      = op_class(ir[OPC_HI:OPC_LO]);
    assign unused_rsvd = ^{instr[2:0], ir[2:0]};

    eu_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_nxt    = state;
        ir_load      = 1'b0;
        retire       = 1'b0;
        set_illegal  = 1'b0;
        set_timeout  = 1'b0;
        tmr_clear    = 1'b0;
        tmr_en       = 1'b0;
        instr_ready  = 1'b0;
        dmem_req     = 1'b0;
        rf_wr_gate   = 1'b0;
        dmem_wr_gate = 1'b0;
        busy         = 1'b1;
        eu_opcode    = ir[OPC_HI:OPC_LO];
        eu_opA_adr   = ir[SRCA_HI:SRCA_LO];
        eu_opB_adr   = ir[SRCB_HI:SRCB_LO];
        eu_dest      = ir[DEST_HI:DEST_LO];
        case (state)
            ST_IDLE: begin
                busy        = 1'b0;
                instr_ready = 1'b1;
                eu_opcode   = OP_NOP;
                eu_opA_adr  = 3'd0;
                eu_opB_adr  = 3'd0;
                eu_dest     = 3'd0;
                if (instr_valid) begin
                    case (in_cls)
                        CLS_ALU, CLS_LD, CLS_ST: begin
                            ir_load   = 1'b1;
                            state_nxt = ST_ISSUE;
                        end
                        CLS_NOP: retire      = 1'b1;
                        default: set_illegal = 1'b1;
                    endcase
                end
            end
            ST_ISSUE: begin
                tmr_clear = 1'b1;
                case (ir_cls)
                    CLS_LD:  state_nxt = ST_LD_WAIT;
                    CLS_ST:  state_nxt = ST_ST_WAIT;
                    default: state_nxt = ST_WB;
                endcase
            end
            ST_LD_WAIT: begin
                dmem_req = 1'b1;
                tmr_en   = 1'b1;
                if (dmem_ack) begin
                    state_nxt = ST_WB;
                end else if (tmr_expired) begin
                    set_timeout = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_ST_WAIT: begin
                dmem_req     = 1'b1;
                dmem_wr_gate = 1'b1;
                tmr_en       = 1'b1;
                // Ack on the expiry cycle still completes the store.
                if (dmem_ack) begin
                    retire    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmr_expired) begin
                    set_timeout = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_WB: begin
                rf_wr_gate = 1'b1;
                retire     = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            ir    <= IR_NOP;
        end else begin
            state <= state_nxt;
            if (ir_load) begin
                ir <= instr;
            end
        end
    end

    // A set event in the same cycle as err_clr keeps the flag high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
            retire_count <= '0;
        end else begin
            err_illegal <= set_illegal | (err_illegal & ~err_clr);
            err_timeout <= set_timeout | (err_timeout & ~err_clr);
            if (retire) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_eu_issue_ctrl.sv
// Directed self-checking bench for eu_issue_ctrl with MEM_TIMEOUT=4.
module tb_eu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  eu_opcode;
    logic [2:0]  eu_opA_adr;
    logic [2:0]  eu_opB_adr;
    logic [2:0]  eu_dest;
    logic        dmem_req;
    logic        dmem_ack;
    logic        rf_wr_gate;
    logic        dmem_wr_gate;
    logic        busy;
    logic        err_illegal;
    logic        err_timeout;
    logic        err_clr;
    logic [15:0] retire_count;

    int checks;
    int failures;

    eu_issue_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .eu_opcode    (eu_opcode),
        .eu_opA_adr   (eu_opA_adr),
        .eu_opB_adr   (eu_opB_adr),
        .eu_dest      (eu_dest),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .rf_wr_gate   (rf_wr_gate),
        .dmem_wr_gate (dmem_wr_gate),
        .busy         (busy),
        .err_illegal  (err_illegal),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dmem_ack    = 1'b0;
        err_clr     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_opcode", eu_opcode, 4'hF);
        check("rst_opA", eu_opA_adr, 3'd0);
        check("rst_dest", eu_dest, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_rfg", rf_wr_gate, 1'b0);
        check("rst_dwg", dmem_wr_gate, 1'b0);
        check("rst_errs", {err_illegal, err_timeout}, 2'b00);
        check("rst_cnt", retire_count, 16'd0);
        reset = 1'b1;
        tick();

        // ALU 0x1A50
        check("alu_ready", instr_ready, 1'b1);
        instr = 16'h1A50; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("alu_iss_opc", eu_opcode, 4'h1);
        check("alu_iss_A", eu_opA_adr, 3'd1);
        check("alu_iss_B", eu_opB_adr, 3'd2);
        check("alu_iss_dest", eu_dest, 3'd5);
        check("alu_iss_rfg", rf_wr_gate, 1'b0);
        check("alu_iss_ready", instr_ready, 1'b0);
        check("alu_iss_busy", busy, 1'b1);
        tick();
        check("alu_wb_rfg", rf_wr_gate, 1'b1);
        check("alu_wb_dest", eu_dest, 3'd5);
        tick();
        check("alu_done_rfg", rf_wr_gate, 1'b0);
        check("alu_done_cnt", retire_count, 16'd1);
        check("alu_done_opc", eu_opcode, 4'hF);

        // LD 0x4600, ack on the 3rd wait cycle
        instr = 16'h4600; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("ld_iss_req", dmem_req, 1'b0);
        check("ld_iss_opc", eu_opcode, 4'h4);
        tick();
        check("ld_w1_req", dmem_req, 1'b1);
        check("ld_w1_dwg", dmem_wr_gate, 1'b0);
        tick();
        check("ld_w2_req", dmem_req, 1'b1);
        tick();
        check("ld_w3_req", dmem_req, 1'b1);
        check("ld_w3_dwg", dmem_wr_gate, 1'b0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("ld_wb_req", dmem_req, 1'b0);
        check("ld_wb_rfg", rf_wr_gate, 1'b1);
        check("ld_wb_dest", eu_dest, 3'd3);
        check("ld_wb_dwg", dmem_wr_gate, 1'b0);
        tick();
        check("ld_done_cnt", retire_count, 16'd2);

        // ST 0x5080, ack on the 1st wait cycle
        instr = 16'h5080; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("st_iss_dwg", dmem_wr_gate, 1'b0);
        check("st_iss_A", eu_opA_adr, 3'd2);
        tick();
        check("st_w1_dwg", dmem_wr_gate, 1'b1);
        check("st_w1_req", dmem_req, 1'b1);
        check("st_w1_rfg", rf_wr_gate, 1'b0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("st_done_dwg", dmem_wr_gate, 1'b0);
        check("st_done_rfg", rf_wr_gate, 1'b0);
        check("st_done_ready", instr_ready, 1'b1);
        check("st_done_cnt", retire_count, 16'd3);

        // LD timeout, no ack for 4 wait cycles
        instr = 16'h4200; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("to_w4_req", dmem_req, 1'b1);
        check("to_w4_err", err_timeout, 1'b0);
        tick();
        check("to_err", err_timeout, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_rfg", rf_wr_gate, 1'b0);
        check("to_cnt", retire_count, 16'd3);
        tick();
        check("to_nowb", rf_wr_gate, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr", err_timeout, 1'b0);

        // LD with ack on the 4th wait cycle
        instr = 16'h4200; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("ack4_rfg", rf_wr_gate, 1'b1);
        check("ack4_dest", eu_dest, 3'd1);
        tick();
        check("ack4_err", err_timeout, 1'b0);
        check("ack4_cnt", retire_count, 16'd4);

        // Illegal then NOP
        instr = 16'h7000; instr_valid = 1'b1;
        tick();
        check("ill_err", err_illegal, 1'b1);
        check("ill_cnt", retire_count, 16'd4);
        check("ill_busy", busy, 1'b0);
        instr = 16'hF000;
        tick();
        check("nop_cnt", retire_count, 16'd5);
        check("nop_busy", busy, 1'b0);
        instr = 16'h8000; err_clr = 1'b1;
        tick();
        check("ill_clr_race", err_illegal, 1'b1);
        instr_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        check("ill_clr", err_illegal, 1'b0);
        check("ill2_cnt", retire_count, 16'd5);

        // Async reset during LD_WAIT
        instr = 16'h4600; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("rl_req_pre", dmem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rl_req", dmem_req, 1'b0);
        check("rl_rfg", rf_wr_gate, 1'b0);
        check("rl_dwg", dmem_wr_gate, 1'b0);
        check("rl_busy", busy, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check("rl_cnt", retire_count, 16'd0);
        check("rl_opc", eu_opcode, 4'hF);
        check("rl_ready", instr_ready, 1'b1);

        // Async reset during ST_WAIT drops the store gate
        instr = 16'h5080; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("rs_dwg_pre", dmem_wr_gate, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rs_dwg", dmem_wr_gate, 1'b0);
        check("rs_req", dmem_req, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check("rs_cnt", retire_count, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eu_issue_ctrl.md
Name: eu_issue_ctrl

Overview:
Single-issue instruction sequencer placed in front of the execution unit (EU).
- Accepts 16-bit instruction words over a valid/ready handshake and decodes the opcode and register fields.
- Drives the EU opcode/address inputs and handshakes with data memory for loads and stores.
- Gates the EU's registered write enables so register-file and data-memory writes happen exactly once per instruction.
- Also tracks retired-instruction count and sticky error flags.

Parameters:
- MEM_TIMEOUT, 16, max cycles in a memory-wait state without dmem_ack before abort (legal range 1..255).
- CNT_W, 16, width of retire_count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted = 0).
- instr_valid  in  1  instruction word valid.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  16  [15:12] opcode, [11:9] dest, [8:6] srcA, [5:3] srcB, [2:0] reserved (ignored).
- eu_opcode  out  4  to EU opcode.
- eu_opA_adr  out  3  to EU operand-A address.
- eu_opB_adr  out  3  to EU operand-B address.
- eu_dest  out  3  to EU destination register.
- dmem_req  out  1  data-memory access request.
- dmem_ack  in  1  data memory done; load data valid in the same cycle.
- rf_wr_gate  out  1  ANDed with EU write_enable at the register file.
- dmem_wr_gate  out  1  ANDed with EU data_memory_write_enable.
- busy  out  1  state != IDLE.
- err_illegal  out  1  sticky; an illegal opcode was offered.
- err_timeout  out  1  sticky; a memory wait timed out.
- err_clr  in  1  clears both sticky flags.
- retire_count  out  CNT_W  instructions retired, wraps modulo 2^CNT_W.

Behaviour:
- Opcode classes:
  - ALU = 0x0..0x3.
  - LD = 0x4.
  - ST = 0x5.
  - NOP = 0xF.
  - 0x6..0xE are illegal.
- States: IDLE, ISSUE, LD_WAIT, ST_WAIT, WB. Registered state; outputs decode from state plus the latched instruction register (ir).
- Reset values:
  - state=IDLE, ir=0x F000 (NOP).
  - eu_opcode=0xF, eu address outputs=0.
  - dmem_req=0, rf_wr_gate=0, dmem_wr_gate=0, busy=0.
  - err flags=0, retire_count=0, timer=0.
- Reset is asynchronous. Asserting it mid-instruction drops both gates and dmem_req immediately; the instruction is lost and not counted.
- IDLE:
  - instr_ready=1 and EU outputs show NOP (0xF, addresses 0).
  - On valid&ready with ALU/LD/ST: latch instr into ir, then ISSUE.
  - NOP: accepted, retire_count+1, stay IDLE.
  - Illegal: accepted and dropped, err_illegal=1, stay IDLE, no count.
- instr_ready=0 in every state other than IDLE.
- ISSUE (1 cycle): drive ir fields to the EU; the EU captures at the closing edge.
  - ALU goes to WB.
  - LD goes to LD_WAIT.
  - ST goes to ST_WAIT.
- LD_WAIT:
  - dmem_req=1 and ir fields held.
  - On dmem_ack, the EU captures load data at that edge, then WB.
- ST_WAIT:
  - dmem_req=1, dmem_wr_gate=1 and ir fields held.
  - On dmem_ack: retire_count+1, then IDLE.
- WB (1 cycle): rf_wr_gate=1 with eu_dest still = ir dest; retire_count+1; then IDLE.
- Timer:
  - Cleared on entry to LD_WAIT or ST_WAIT; increments each cycle in those states.
  - When timer reaches MEM_TIMEOUT-1 without ack: err_timeout=1, return to IDLE with no write and no retire.
  - If ack arrives in that same cycle, ack wins and there is no error.
- Latency, accept to retire: ALU 3 cycles (IDLE, ISSUE, WB); LD 4+wait cycles; ST 3+wait cycles.
- Error flags: err_clr clears both. A set event in the same cycle as err_clr wins (flag stays 1).
- busy is high in ISSUE, LD_WAIT, ST_WAIT and WB.

Decomposition:
- Shared package eu_pkg holds:
  - opcode constants (OP_LD=4'h4, OP_ST=4'h5, OP_NOP=4'hF, ALU range);
  - instruction field bit positions;
  - state enum eu_seq_state_t.
- One sub-module, eu_mem_timer: clear/enable/expire counter parameterised by MEM_TIMEOUT.

Test Plan:
- Reset release, then instr=0x1A50 (ALU op1, dest5, A1, B2) -> ISSUE shows eu_opcode=1, eu_opA_adr=1, eu_opB_adr=2, eu_dest=5; rf_wr_gate=1 exactly one cycle, 2 cycles after accept; retire_count=1.
- LD 0x4600, dmem_ack after 3 cycles in LD_WAIT -> dmem_req high 3 cycles; WB on the next cycle with eu_dest=3; dmem_wr_gate never asserted.
- ST 0x5080, dmem_ack on the 1st LD/ST-wait cycle -> dmem_wr_gate=1 for exactly 1 cycle; rf_wr_gate stays 0; retire_count+1; instr_ready returns 1 the next cycle.
- LD with MEM_TIMEOUT=4 and no ack -> err_timeout=1 after 4 LD_WAIT cycles, no WB, count unchanged. Separately, ack on the 4th cycle -> no error, normal WB.
- Offer 0x7000 then 0xF000 -> err_illegal=1 with count unchanged, then NOP count+1. err_clr pulsed in the same cycle as another illegal op -> flag stays 1.
- Assert reset (0) during LD_WAIT -> dmem_req, rf_wr_gate and dmem_wr_gate go to 0 asynchronously; after release: IDLE, retire_count=0, eu_opcode=0xF.
